// File: rtl/ttt_pkg.sv
// ttt_pkg: shared definitions for the tic-tac-toe move path.
//   ASCII framing constants, receiver error codes and receiver FSM states.
package ttt_pkg;

   localparam logic [7:0] CR     = 8'h0D;
   localparam logic [7:0] LF     = 8'h0A;
   localparam logic [7:0] SPACE  = 8'h20;
   localparam logic [7:0] DIGIT0 = 8'h30;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'd0,
      ERR_CHAR     = 2'd1,
      ERR_OCCUPIED = 2'd2,
      ERR_TIMEOUT  = 2'd3
   } err_code_e;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      WAIT_DIGIT = 3'd1,
      WAIT_TERM  = 3'd2,
      CHECK      = 3'd3,
      DONE       = 3'd4
   } rx_state_e;

endpackage

// File: rtl/move_char_decode.sv
// move_char_decode: combinational classifier for one received byte.
//   byte_i     : received ASCII byte
//   is_digit_o : byte is '1'..('0'+CELLS)
//   is_term_o  : byte is CR or LF
//   is_skip_o  : byte is CR, LF or space (ignored while waiting for a digit)
//   cell_oh_o  : one-hot cell for a digit byte ('1' -> bit 0), zero otherwise
module move_char_decode
   import ttt_pkg::*;
#(
   parameter int CELLS = 9
) (
   input  logic [7:0]       byte_i,
   output logic             is_digit_o,
   output logic             is_term_o,
   output logic             is_skip_o,
   output logic [CELLS-1:0] cell_oh_o
);

   always_comb begin
      is_term_o  = (byte_i == CR) || (byte_i == LF);
      is_skip_o  = is_term_o || (byte_i == SPACE);
      is_digit_o = (byte_i >= (DIGIT0 + 8'd1)) && (byte_i <= (DIGIT0 + 8'(CELLS)));
      cell_oh_o  = '0;
      for (int unsigned i = 0; i < CELLS; i++) begin
         cell_oh_o[i] = (byte_i == (DIGIT0 + 8'(i + 1)));
      end
   end

endmodule

// File: rtl/move_receiver.sv
// move_receiver: responder for the game manager's opponent-move handshake.
//   clk, reset (async, active low)
//   recv_req         : one-cycle request pulse; accepted only when idle
//   recv_ready       : idle, results valid (combinational, low during recv_req)
//   recv_error       : last move rejected
//   recv_error_code  : 0 none, 1 bad char, 2 occupied cell, 3 timeout
//   my_target_a      : 1 -> opponent moves go to board B, 0 -> to board A
//   board_a/board_b  : current boards, latched on accept
//   recv_board_a/b   : resulting boards
//   rx_data/rx_valid : UART RX byte stream, move = digit then CR/LF
module move_receiver
   import ttt_pkg::*;
#(
   parameter int ROWS           = 3,
   parameter int COLS           = 3,
   parameter int TIMEOUT_CYCLES = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 recv_req,
   output logic                 recv_ready,
   output logic                 recv_error,
   output logic [1:0]           recv_error_code,
   input  logic                 my_target_a,
   input  logic [ROWS*COLS-1:0] board_a,
   input  logic [ROWS*COLS-1:0] board_b,
   output logic [ROWS*COLS-1:0] recv_board_a,
   output logic [ROWS*COLS-1:0] recv_board_b,
   input  logic [7:0]           rx_data,
   input  logic                 rx_valid
);

   localparam int CELLS = ROWS * COLS;
   localparam int CW    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] TO_CAP  = CW'(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

   if (CELLS < 1 || CELLS > 9) begin : g_bad_size
      $error("move_receiver: ROWS*COLS must be 1..9");
   end

   rx_state_e          state_q, state_d;
   err_code_e          code_q, code_d;
   logic               err_q, err_d;
   logic               target_q, target_d;
   logic [CELLS-1:0]   cell_q, cell_d;
   logic [CELLS-1:0]   brd_a_q, brd_a_d;
   logic [CELLS-1:0]   brd_b_q, brd_b_d;
   logic [CW-1:0]      cnt_q, cnt_d;

   logic               is_digit, is_term, is_skip;
   logic [CELLS-1:0]   cell_oh;
   logic               timeout_hit;

   move_char_decode #(.CELLS(CELLS)) u_decode (
      .byte_i     (rx_data),
      .is_digit_o (is_digit),
      .is_term_o  (is_term),
      .is_skip_o  (is_skip),
      .cell_oh_o  (cell_oh)
   );

   // Counter saturates at TIMEOUT_CYCLES so it never wraps while a byte
   // holds off the timeout on the final cycle.
   assign timeout_hit = (TIMEOUT_CYCLES > 0) && (cnt_q >= TO_LAST);

   always_comb begin
      state_d  = state_q;
      code_d   = code_q;
      err_d    = err_q;
      target_d = target_q;
      cell_d   = cell_q;
      brd_a_d  = brd_a_q;
      brd_b_d  = brd_b_q;
      cnt_d    = cnt_q;

      case (state_q)
         IDLE: begin
            if (recv_req) begin
               brd_a_d  = board_a;
               brd_b_d  = board_b;
               target_d = my_target_a;
               err_d    = 1'b0;
               code_d   = ERR_NONE;
               cnt_d    = '0;
               state_d  = WAIT_DIGIT;
            end
         end
         WAIT_DIGIT: begin
            if ((TIMEOUT_CYCLES > 0) && (cnt_q < TO_CAP)) cnt_d = cnt_q + CW'(1);
            if (rx_valid) begin
               if (is_digit) begin
                  cell_d  = cell_oh;
                  state_d = WAIT_TERM;
               end else if (!is_skip) begin
                  code_d  = ERR_CHAR;
                  state_d = DONE;
               end
            end else if (timeout_hit) begin
               code_d  = ERR_TIMEOUT;
               state_d = DONE;
            end
         end
         WAIT_TERM: begin
            if ((TIMEOUT_CYCLES > 0) && (cnt_q < TO_CAP)) cnt_d = cnt_q + CW'(1);
            if (rx_valid) begin
               if (is_term) begin
                  state_d = CHECK;
               end else begin
                  code_d  = ERR_CHAR;
                  state_d = DONE;
               end
            end else if (timeout_hit) begin
               code_d  = ERR_TIMEOUT;
               state_d = DONE;
            end
         end
         CHECK: begin
            if (((brd_a_q | brd_b_q) & cell_q) != '0) begin
               code_d = ERR_OCCUPIED;
            end else if (target_q) begin
               brd_b_d = brd_b_q | cell_q;
            end else begin
               brd_a_d = brd_a_q | cell_q;
            end
            state_d = DONE;
         end
         DONE: begin
            err_d   = (code_q != ERR_NONE);
            state_d = IDLE;
         end
         default: begin
            state_d  = IDLE;
            code_d   = ERR_NONE;
            err_d    = 1'b0;
            target_d = 1'b0;
            cell_d   = '0;
            brd_a_d  = '0;
            brd_b_d  = '0;
            cnt_d    = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         code_q   <= ERR_NONE;
         err_q    <= 1'b0;
         target_q <= 1'b0;
         cell_q   <= '0;
         brd_a_q  <= '0;
         brd_b_q  <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         code_q   <= code_d;
         err_q    <= err_d;
         target_q <= target_d;
         cell_q   <= cell_d;
         brd_a_q  <= brd_a_d;
         brd_b_q  <= brd_b_d;
         cnt_q    <= cnt_d;
      end
   end

   assign recv_ready      = (state_q == IDLE) && !recv_req;
   assign recv_error      = err_q;
   assign recv_error_code = code_q;
   assign recv_board_a    = brd_a_q;
   assign recv_board_b    = brd_b_q;

endmodule
